// File: rtl/ray_dispatcher_if.sv
// Generator-to-dispatcher ray channel: one buffered ray handshake plus the generator busy flag.
// master = ray generator side, slave = dispatcher side.
interface ray_dispatcher_if #(
    parameter int unsigned POSITION_WIDTH = 16,
    parameter int unsigned ADDRESS_WIDTH  = 32
);
    logic                               genBusy;
    logic                               inStart;
    logic                               inReady;
    logic signed [3*POSITION_WIDTH-1:0] inRayV;
    logic        [ADDRESS_WIDTH-1:0]    inAddress;

    modport master (
        output genBusy,
        output inStart,
        output inRayV,
        output inAddress,
        input  inReady
    );

    modport slave (
        input  genBusy,
        input  inStart,
        input  inRayV,
        input  inAddress,
        output inReady
    );
endinterface

// File: rtl/ray_dispatcher.sv
// One-entry ray buffer fanning out to UNITS ray units in round-robin order, with frame-done detection.
// Optional RAY_DISPATCH_STATS_EN adds rayCount/stallCount frame statistics outputs.
module ray_dispatcher #(
    parameter int unsigned POSITION_WIDTH = 16,
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned UNITS          = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    ray_dispatcher_if.slave                    gen,
    output logic        [UNITS-1:0]            unitStart,
    input  logic        [UNITS-1:0]            unitReady,
    input  logic        [UNITS-1:0]            unitBusy,
    output logic signed [3*POSITION_WIDTH-1:0] rayV,
    output logic        [ADDRESS_WIDTH-1:0]    rayAddress,
    output logic                               busy,
    output logic                               done
`ifdef RAY_DISPATCH_STATS_EN
    ,
    output logic        [31:0]                 rayCount,
    output logic        [31:0]                 stallCount
`endif
);
    localparam int unsigned PtrW = (UNITS > 1) ? $clog2(UNITS) : 1;
    localparam int unsigned VecW = 3 * POSITION_WIDTH;

    typedef enum logic {StEmpty, StFull} state_t;

    state_t                     state_q, state_d;
    logic [PtrW-1:0]            ptr_q, ptr_d;
    logic [UNITS-1:0]           start_q, start_d;
    logic signed [VecW-1:0]     rayv_q, rayv_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       found;
    logic [PtrW-1:0]            sel;
    logic [PtrW-1:0]            cand;
    int unsigned                wrap;
    logic                       capture;
    logic                       dispatch;
    logic                       stall;

    // Round-robin search: first ready unit at or after ptr_q, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        wrap  = 0;
        for (int unsigned i = 0; i < UNITS; i++) begin
            wrap = int'(ptr_q) + i;
            if (wrap >= UNITS) begin
                wrap = wrap - UNITS;
            end
            cand = PtrW'(wrap);
            if (!found && unitReady[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        start_d  = '0;
        rayv_d   = rayv_q;
        addr_d   = addr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        capture  = 1'b0;
        dispatch = 1'b0;
        stall    = 1'b0;

        case (state_q)
            StEmpty: begin
                if (gen.inStart) begin
                    capture = 1'b1;
                    state_d = StFull;
                    rayv_d  = gen.inRayV;
                    addr_d  = gen.inAddress;
                    busy_d  = 1'b1;
                end
            end
            StFull: begin
                if (found) begin
                    dispatch     = 1'b1;
                    state_d      = StEmpty;
                    start_d[sel] = 1'b1;
                    if (int'(sel) == int'(UNITS) - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = sel + 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StEmpty;
        endcase

        // A capture in the same cycle keeps the frame open, hence the inStart term.
        if (busy_q && !gen.genBusy && (state_q == StEmpty) && !gen.inStart &&
            (start_q == '0) && (unitBusy == '0)) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            start_q <= '0;
            rayv_q  <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
            rayv_q  <= rayv_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gen.inReady = (state_q == StEmpty);
    assign unitStart   = start_q;
    assign rayV        = rayv_q;
    assign rayAddress  = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef RAY_DISPATCH_STATS_EN
    logic [31:0] ray_cnt_q, ray_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters restart on the first capture of a new frame and saturate.
    always_comb begin
        ray_cnt_d   = ray_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (capture && !busy_q) begin
            ray_cnt_d   = '0;
            stall_cnt_d = '0;
        end else begin
            if (dispatch && (ray_cnt_q != '1)) begin
                ray_cnt_d = ray_cnt_q + 32'd1;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ray_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ray_cnt_q   <= ray_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rayCount   = ray_cnt_q;
    assign stallCount = stall_cnt_q;
`endif
endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Parametrised ray fan-out stage that sits between the ray generator and a bank of `UNITS` ray units, replacing the single generator-to-unit connection. It buffers one ray from the generator and hands it to the next ready unit in round-robin order. It tracks frame completion across all units and raises a one-cycle `done` pulse when the generator and every unit have gone idle.

## Interface
- `POSITION_WIDTH`, 16: width of each ray direction component.
- `ADDRESS_WIDTH`, 32: pixel address width.
- `UNITS`, 4: number of downstream ray units, 1..16.

- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `genBusy`  in  1  generator still producing rays for the current frame.
- `inStart`  in  1  ray valid from generator; honoured only while `inReady`=1.
- `inReady`  out  1  buffer empty, ray accepted this cycle if `inStart`=1.
- `inRayV`  in  3×POSITION_WIDTH  signed ray direction.
- `inAddress`  in  ADDRESS_WIDTH  pixel address for the ray.
- `unitStart`  out  UNITS  one-hot start pulse to the selected unit.
- `unitReady`  in  UNITS  unit can accept a ray.
- `unitBusy`  in  UNITS  unit is tracing or writing a ray.
- `rayV`  out  3×POSITION_WIDTH  buffered direction, broadcast to all units.
- `rayAddress`  out  ADDRESS_WIDTH  buffered pixel address, broadcast.
- `busy`  out  1  frame in progress (armed).
- `done`  out  1  one-cycle frame-complete pulse.

## Operation
- Buffer state is EMPTY or FULL. `inReady` is a register and equals (state==EMPTY).
- EMPTY with `inStart`=1: capture `inRayV` and `inAddress` into `rayV` and `rayAddress`, go to FULL, set `busy`=1.
- FULL: search `unitReady` starting at pointer `ptr` and wrapping modulo UNITS. At the first ready index k:
  - assert `unitStart[k]` next cycle,
  - return to EMPTY,
  - set `ptr` = (k+1) mod UNITS.
- FULL with no unit ready: hold the buffer and all outputs.
- `rayV` and `rayAddress` change only on capture. They stay stable through the `unitStart` cycle.
- Unit contract: a unit deasserts `unitReady` no later than the cycle after it samples `unitStart`.
- Completion: with `busy`=1, the following must all hold for one cycle:
  - `genBusy`=0,
  - state EMPTY,
  - `unitStart`=0,
  - `unitBusy`==0.
  - Then the next cycle has `done`=1 and `busy`=0.
- `inStart` in the same cycle as the completion condition blocks completion, because it captures into the buffer.
- UNITS=1 degenerates to pass-through with `ptr` fixed at 0.

## Timing
- Reset values: `inReady`=1, all other outputs 0, `ptr`=0, state EMPTY. This also applies to a reset asserted mid-frame: any buffered ray is discarded and no `done` is produced.
- Capture at edge E. The earliest `unitStart` is at E+1, and `inReady` returns to 1 at E+1. Sustained throughput is 1 ray per 2 cycles.
- `unitStart` is high for exactly one cycle per ray and is never multi-hot.
- `done` asserts 1 cycle after the completion condition is sampled.

## Configuration
- `RAY_DISPATCH_STATS_EN` defined:
  - Adds output `rayCount` (32 bits): rays dispatched in the current/last frame.
  - Adds output `stallCount` (32 bits): cycles spent FULL with no unit ready.
  - Both clear on the first capture after `busy`=0, saturate at all-ones, and hold after `done`.
- `RAY_DISPATCH_STATS_EN` not defined: ports and counters are absent, with identical dispatch behaviour.

## Test plan
- UNITS=4, all units ready, genBusy=1, 8 rays sent back-to-back → `unitStart` sequence 0,1,2,3,0,1,2,3, one ray every 2 cycles, `rayAddress` matches input order.
- Units 1 and 3 only ready, `ptr`=0 → first ray to unit 1, second to unit 3, third to unit 1.
- No unit ready for 10 cycles with the buffer FULL → `inReady`=0 and outputs held; unit 2 readies → `unitStart`=0100 next cycle, `stallCount`=10 with STATS_EN.
- After the last ray, genBusy falls while unit 0 is still busy for 20 cycles → `done` single pulse 1 cycle after `unitBusy` reaches 0; `busy` drops with it; `rayCount`=number of rays sent.
- Reset asserted while FULL → `inReady`=1, `unitStart`=0, `busy`=0 asynchronously; no `done`; the next frame starts at unit 0.
- UNITS=1, 3 rays → each dispatched to unit 0 after its ready; `done` once at the end.
